// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one MDIO engine among four requesters.
// Latches the winner's command, runs the start/ready handshake, returns the result.
module mdio_arbiter #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  req,
    input  logic [3:0]  req_op,
    input  logic [19:0] req_phy,
    input  logic [19:0] req_reg,
    input  logic [63:0] req_wdata,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [3:0]  err,
    output logic [15:0] rdata,
    output logic        eng_start,
    output logic        eng_op,
    output logic [4:0]  eng_phy,
    output logic [4:0]  eng_reg,
    output logic [15:0] eng_wdata,
    input  logic        eng_ready,
    input  logic [15:0] eng_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    last;
    logic [1:0]    win;
    logic [1:0]    idx;
    logic          win_vld;
    logic [CW-1:0] cnt;
    logic          cnt_hit;
    logic          tout;
    logic          to_evt;
    logic          rd_evt;

    // round-robin search starting one past the last winner
    always_comb begin
        win     = last;
        idx     = last;
        win_vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    // state register; reset aborts any transaction in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // next state, completion/timeout events and pulse outputs
    always_comb begin
        state_nx  = state;
        cnt_hit   = (cnt == TMAX);
        to_evt    = 1'b0;
        rd_evt    = 1'b0;
        eng_start = 1'b0;
        done      = 4'b0000;
        err       = 4'b0000;
        unique case (state)
            IDLE: begin
                if (win_vld) state_nx = ISSUE;
            end
            ISSUE: begin
                eng_start = 1'b1;
                state_nx  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (cnt_hit) begin
                    to_evt   = 1'b1;
                    state_nx = RESP;
                end else if (!eng_ready) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (eng_ready) begin
                    rd_evt   = 1'b1;
                    state_nx = RESP;
                end else if (cnt_hit) begin
                    to_evt   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (tout) err  = gnt;
                else      done = gnt;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // command latch, grant, timeout counter and read-data capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt       <= 4'b0000;
            last      <= 2'd3;
            eng_op    <= 1'b0;
            eng_phy   <= 5'd0;
            eng_reg   <= 5'd0;
            eng_wdata <= 16'h0000;
            rdata     <= 16'h0000;
            cnt       <= '0;
            tout      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt       <= 4'b0001 << win;
                        last      <= win;
                        eng_op    <= req_op[win];
                        eng_phy   <= req_phy[5*win +: 5];
                        eng_reg   <= req_reg[5*win +: 5];
                        eng_wdata <= req_wdata[16*win +: 16];
                        tout      <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (!cnt_hit) cnt <= cnt + 1'b1;
                    if (to_evt) begin
                        tout  <= 1'b1;
                        rdata <= 16'hFFFF;
                    end else if (rd_evt && !eng_op) begin
                        rdata <= eng_rdata;
                    end
                end
                RESP: begin
                    gnt <= 4'b0000;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: directed scenarios with randomized data and engine timing.
// A small engine model and a round-robin reference predict every outcome.
module tb_mdio_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  req;
    logic [3:0]  req_op;
    logic [19:0] req_phy;
    logic [19:0] req_reg;
    logic [63:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [15:0] rdata;
    logic        eng_start;
    logic        eng_op;
    logic [4:0]  eng_phy;
    logic [4:0]  eng_reg;
    logic [15:0] eng_wdata;
    logic        eng_ready;
    logic [15:0] eng_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ready_cyc = 0;
    int n_start = 0;
    int busy_dly = 3;
    int busy_len = 10;
    bit never_busy = 1'b0;
    logic [15:0] rd_val = 16'h0000;

    int m_last = 3;
    logic [15:0] m_rdata = 16'h0000;

    mdio_arbiter #(.TIMEOUT_CYC(50)) dut (
        .CLK(CLK),
        .RST(RST),
        .req(req),
        .req_op(req_op),
        .req_phy(req_phy),
        .req_reg(req_reg),
        .req_wdata(req_wdata),
        .gnt(gnt),
        .done(done),
        .err(err),
        .rdata(rdata),
        .eng_start(eng_start),
        .eng_op(eng_op),
        .eng_phy(eng_phy),
        .eng_reg(eng_reg),
        .eng_wdata(eng_wdata),
        .eng_ready(eng_ready),
        .eng_rdata(eng_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // engine model: goes busy busy_dly cycles after start, ready busy_len later
    initial begin
        eng_ready = 1'b1;
        eng_rdata = 16'h0000;
        forever begin
            @(negedge CLK);
            if (eng_start) begin
                start_cyc = cyc;
                n_start++;
                if (!never_busy) begin
                    repeat (busy_dly) @(negedge CLK);
                    eng_ready = 1'b0;
                    eng_rdata = 16'($urandom);
                    repeat (busy_len) @(negedge CLK);
                    eng_rdata = rd_val;
                    eng_ready = 1'b1;
                    ready_cyc = cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++) begin
            if (r[(lst + k) % 4]) return (lst + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit op, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd);
        req_op[i]            = op;
        req_phy[5*i +: 5]    = phy;
        req_reg[5*i +: 5]    = rg;
        req_wdata[16*i +: 16] = wd;
        req[i]               = 1'b1;
    endtask

    task automatic rand_engine();
        busy_dly = $urandom_range(1, 4);
        busy_len = $urandom_range(1, 30);
        rd_val   = 16'($urandom);
    endtask

    task automatic do_txn(input string tag, input bit drop_mid);
        int w;
        int k;
        int n0;
        int dc;
        bit to;
        logic [15:0] exp_rd;
        logic [31:0] oh;
        w  = pick(req, m_last);
        to = never_busy;
        n0 = n_start;
        oh = 32'(1) << w;
        k = 0;
        while (gnt === 4'b0000 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk({tag, "_gnt"}, 32'(gnt), oh);
        chk({tag, "_op"}, 32'(eng_op), 32'(req_op[w]));
        chk({tag, "_phy"}, 32'(eng_phy), 32'(req_phy[5*w +: 5]));
        chk({tag, "_reg"}, 32'(eng_reg), 32'(req_reg[5*w +: 5]));
        chk({tag, "_wd"}, 32'(eng_wdata), 32'(req_wdata[16*w +: 16]));
        if (drop_mid) begin
            @(negedge CLK);
            set_req(3, 1'b0, 5'd7, 5'd7, 16'h7777);
            repeat (4) @(negedge CLK);
            req[w] = 1'b0;
            req[3] = 1'b0;
        end
        k = 0;
        while (done === 4'b0000 && err === 4'b0000 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk({tag, "_bound"}, 32'(k < 300), 32'd1);
        dc = cyc;
        if (to)            exp_rd = 16'hFFFF;
        else if (req_op[w]) exp_rd = m_rdata;
        else               exp_rd = rd_val;
        chk({tag, "_done"}, 32'(done), to ? 32'd0 : oh);
        chk({tag, "_err"}, 32'(err), to ? oh : 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        if (to) chk({tag, "_tolat"}, 32'(dc - start_cyc >= 51 && dc - start_cyc <= 52), 32'd1);
        else    chk({tag, "_lat"}, 32'(dc - ready_cyc), 32'd1);
        m_rdata = exp_rd;
        m_last  = w;
        req[w]  = 1'b0;
        @(negedge CLK);
        chk({tag, "_pulse"}, 32'({done, err}), 32'd0);
        chk({tag, "_gntclr"}, 32'(gnt), 32'd0);
        chk({tag, "_starts"}, 32'(n_start - n0), 32'd1);
    endtask

    initial begin
        int k;
        RST       = 1'b1;
        req       = 4'b0000;
        req_op    = 4'b0000;
        req_phy   = '0;
        req_reg   = '0;
        req_wdata = '0;
        repeat (3) @(negedge CLK);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_pulses", 32'({done, err, eng_start}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_cmd", 32'({eng_op, eng_phy, eng_reg, eng_wdata}), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // round robin with all four requesting
        for (int i = 0; i < 4; i++)
            set_req(i, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            rand_engine();
            do_txn($sformatf("rr%0d", i), 1'b0);
        end
        set_req(1, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        set_req(3, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom));
        rand_engine();
        do_txn("rr13_a", 1'b0);
        rand_engine();
        do_txn("rr13_b", 1'b0);

        // single read from requester 2
        busy_dly = 3;
        busy_len = 40;
        rd_val   = 16'h796D;
        set_req(2, 1'b0, 5'd1, 5'd2, 16'($urandom));
        do_txn("read", 1'b0);

        // write from requester 0 leaves rdata untouched
        rand_engine();
        set_req(0, 1'b1, 5'($urandom), 5'd0, 16'h1200);
        do_txn("write", 1'b0);

        // requester 1 withdraws; a late requester 3 withdraws before grant
        rand_engine();
        busy_len = 25;
        set_req(1, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        do_txn("withdraw", 1'b1);
        repeat (5) @(negedge CLK);
        chk("ghost", 32'(gnt), 32'd0);

        // engine never goes busy: timeout
        never_busy = 1'b1;
        set_req(3, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        do_txn("timeout", 1'b0);
        never_busy = 1'b0;
        rand_engine();
        set_req(2, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        do_txn("post_to", 1'b0);

        // reset during WAIT_DONE
        busy_dly = 2;
        busy_len = 30;
        rd_val   = 16'($urandom);
        set_req(2, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom));
        k = 0;
        while (eng_ready === 1'b1 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        chk("mid_busy", 32'(eng_ready), 32'd0);
        repeat (3) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("mid_gnt", 32'(gnt), 32'd0);
        chk("mid_pulses", 32'({done, err, eng_start}), 32'd0);
        chk("mid_rdata", 32'(rdata), 32'd0);
        req = 4'b0000;
        @(negedge CLK);
        RST     = 1'b0;
        m_last  = 3;
        m_rdata = 16'h0000;
        k = 0;
        while (eng_ready !== 1'b1 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        @(negedge CLK);
        rand_engine();
        set_req(2, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
        set_req(0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
        do_txn("post_rst_a", 1'b0);
        rand_engine();
        do_txn("post_rst_b", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdio_arbiter.md
# mdio_arbiter

Round-robin arbiter and sequencer that shares one MDIO transaction engine (the `mdioControl` master driving MDIO/mdCLK) between four on-chip requesters. It latches the winning requester's command, pulses the engine's start and tracks its ready handshake to completion. It then returns read data and a one-cycle done or error pulse to that requester. It sits between the PHY-management clients (link poller, init sequencer, debug port, host) and the single MDIO master.

## Interface
- `TIMEOUT_CYC`, 1_000_000: cycles allowed from engine start to completion before the transaction is aborted.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-requester request; held high until that requester's `done` or `err`.
- `req_op`  in  4  per-requester op: 1 = write, 0 = read.
- `req_phy`  in  20  per-requester PHY address; requester i uses bits [5i+4:5i].
- `req_reg`  in  20  per-requester register address; requester i uses bits [5i+4:5i].
- `req_wdata`  in  64  per-requester write data; requester i uses bits [16i+15:16i].
- `gnt`  out  4  one-hot grant, held for the whole transaction.
- `done`  out  4  one-cycle completion pulse to the owner.
- `err`  out  4  one-cycle timeout pulse to the owner; asserted instead of `done`.
- `rdata`  out  16  read result, valid in the `done` cycle and held until the next completion.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_op`, `eng_phy[4:0]`, `eng_reg[4:0]`, `eng_wdata[15:0]`  out  command registers to the engine.
- `eng_ready`  in  1  engine idle/complete flag; high when idle, low while busy.
- `eng_rdata`  in  16  engine read data; valid when `eng_ready` rises.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- Reset values:
  - state IDLE
  - all outputs 0, including `rdata` = 16'h0000 and the command registers
  - priority pointer `last` = 3, so requester 0 has first priority
- IDLE:
  - If any `req` bit is high, pick the first set bit searching from `last+1` modulo 4.
  - Latch that requester's op/phy/reg/wdata into the `eng_*` registers.
  - Set `gnt`, set `last` = winner, and go to ISSUE.
- ISSUE:
  - `eng_start` = 1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT_BUSY.
- WAIT_BUSY: stay until `eng_ready` = 0, then go to WAIT_DONE.
- WAIT_DONE: stay until `eng_ready` = 1. On the rising edge where `eng_ready` = 1:
  - For a read, capture `eng_rdata` into `rdata`.
  - For a write, leave `rdata` unchanged.
  - Go to RESP.
- RESP:
  - Pulse `done[owner]` for one cycle.
  - Clear `gnt`.
  - Go to IDLE.
- Timeout:
  - The counter runs in WAIT_BUSY and WAIT_DONE.
  - When the count reaches `TIMEOUT_CYC`, go to RESP with `err[owner]` pulsed instead of `done`, and set `rdata` = 16'hFFFF.
  - The counter saturates and does not wrap.
- Boundary conditions:
  - A requester that drops `req` after grant does not abort the transaction; it still completes and `done` still pulses.
  - A requester that drops `req` before being granted is never served.
  - `req` is ignored outside IDLE; requests arriving mid-transaction wait.
  - `eng_ready` glitching high in WAIT_BUSY is ignored; only a low level advances the state.
  - `RST` asserted mid-transaction forces IDLE immediately and clears `gnt` and all pulses. The engine is not notified.
  - Simultaneous requests are granted in rotating order; no requester waits more than 3 other transactions.

## Timing
- Let `req` be sampled high at edge N, with the engine idle.
  - `gnt` and the command registers are valid after edge N.
  - `eng_start` is high during cycle N+1 (ISSUE).
- Engine busy detection takes at least 1 cycle after the start pulse.
- Response latency: `done` is high in the cycle after the edge at which `eng_ready` = 1 was sampled in WAIT_DONE.
- `gnt` falls together with the end of the `done`/`err` cycle.
- Back-to-back transactions: with another `req` pending, its `gnt` rises at the edge after RESP. The minimum IDLE dwell is 1 cycle.
- Command registers are stable from ISSUE through RESP.

## Test plan
- **Single read.** Requester 2 reads phy 1, reg 2. The engine model drops `eng_ready` 3 cycles after start and raises it 40 cycles later with 16'h796D. Required: `gnt` = 0100, one `eng_start` pulse, `rdata` = 16'h796D, `done` = 0100 for exactly 1 cycle.
- **Round robin.** All four `req` bits held high for four transactions. Required: grant order 0,1,2,3. Then reassert 1 and 3: order 1,3.
- **Write.** Requester 0 writes 16'h1200 to reg 0. Required: `eng_op` = 1, `eng_wdata` = 16'h1200, `done` = 0001, `rdata` unchanged from its prior value.
- **Timeout.** With `TIMEOUT_CYC` = 50, the engine never drops `eng_ready`. Required: `err[owner]` pulse 51–52 cycles after start, `rdata` = 16'hFFFF, return to IDLE, and the next request served normally.
- **Request withdrawal.** Requester 1 drops `req` mid-transaction. Required: `done` = 0010 still pulses.
- **Reset mid-transaction.** Assert `RST` during WAIT_DONE. Required: all outputs 0 immediately, and after release requester 0 has first priority.
